// File: rtl/pwm_timer.sv
// Multi-channel timer/PWM generator: one prescaled counter (up, down, up-down, one-shot)
// with double-buffered top/compare values and per-channel PWM and match outputs.
module pwm_timer #(
  parameter int COUNTER_SIZE  = 32,
  parameter int CHANNELS      = 4,
  parameter int PRESCALE_SIZE = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [1:0]                       mode,
  input  logic [PRESCALE_SIZE-1:0]         prescale,
  input  logic [COUNTER_SIZE-1:0]          top,
  input  logic [CHANNELS*COUNTER_SIZE-1:0] compare,
  input  logic                             load,
  input  logic [COUNTER_SIZE-1:0]          load_value,
  output logic [COUNTER_SIZE-1:0]          count,
  output logic                             dir_down,
  output logic                             overflow,
  output logic                             underflow,
  output logic [CHANNELS-1:0]              match,
  output logic [CHANNELS-1:0]              pwm_out,
  output logic                             running
);

  localparam logic [1:0] MODE_UP      = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_UPDOWN  = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam logic [COUNTER_SIZE-1:0]  CNT_ONE = COUNTER_SIZE'(1);
  localparam logic [PRESCALE_SIZE-1:0] PRE_ONE = PRESCALE_SIZE'(1);

  logic [COUNTER_SIZE-1:0]  count_reg, count_next;
  logic [PRESCALE_SIZE-1:0] prescaler_reg, prescaler_next;
  logic                     dir_down_reg, dir_down_next;
  logic                     overflow_reg, overflow_next;
  logic                     underflow_reg, underflow_next;
  logic                     running_reg, running_next;
  logic [CHANNELS-1:0]      match_reg, match_next;
  logic [CHANNELS-1:0]      pwm_reg, pwm_next;
  logic [COUNTER_SIZE-1:0]  top_s_reg, top_s_next;
  logic [COUNTER_SIZE-1:0]  cmp_s_reg  [CHANNELS];
  logic [COUNTER_SIZE-1:0]  cmp_s_next [CHANNELS];
  logic                     shadow_upd;
  logic                     tick;

  assign tick = enable && running_reg && (prescaler_reg == prescale);

  always_comb begin
    count_next     = count_reg;
    prescaler_next = prescaler_reg;
    dir_down_next  = dir_down_reg;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    running_next   = running_reg;
    shadow_upd     = 1'b0;
    if (load) begin
      count_next     = load_value;
      prescaler_next = '0;
      dir_down_next  = 1'b0;
      running_next   = 1'b1;
      shadow_upd     = 1'b1;
    end else if (!enable) begin
      shadow_upd = 1'b1;
    end else begin
      if (mode != MODE_UPDOWN) dir_down_next = 1'b0;
      if (!running_reg) begin
        prescaler_next = '0;
      end else if (!tick) begin
        prescaler_next = prescaler_reg + PRE_ONE;
      end else begin
        prescaler_next = '0;
        case (mode)
          MODE_UP, MODE_ONESHOT: begin
            if (count_reg == top_s_reg) begin
              count_next    = '0;
              overflow_next = 1'b1;
              shadow_upd    = 1'b1;
              if (mode == MODE_ONESHOT) running_next = 1'b0;
            end else begin
              count_next = count_reg + CNT_ONE;
            end
          end
          MODE_DOWN: begin
            // Reload from the incoming top, which becomes the shadow on this same edge.
            if (count_reg == '0) begin
              count_next     = top;
              underflow_next = 1'b1;
              shadow_upd     = 1'b1;
            end else begin
              count_next = count_reg - CNT_ONE;
            end
          end
          default: begin
            if (!dir_down_reg) begin
              if (count_reg == top_s_reg) begin
                dir_down_next = 1'b1;
                overflow_next = 1'b1;
                count_next    = (top_s_reg == '0) ? '0 : top_s_reg - CNT_ONE;
              end else begin
                count_next = count_reg + CNT_ONE;
              end
            end else begin
              // Centre-aligned periods only re-latch their limits at the bottom turn.
              if (count_reg == '0) begin
                dir_down_next  = 1'b0;
                underflow_next = 1'b1;
                shadow_upd     = 1'b1;
                count_next     = (top == '0) ? '0 : CNT_ONE;
              end else begin
                count_next = count_reg - CNT_ONE;
              end
            end
          end
        endcase
      end
    end
  end

  assign top_s_next = shadow_upd ? top : top_s_reg;

  // PWM levels come from next-state count and shadows so they stay consistent across updates.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign cmp_s_next[gi] = shadow_upd ? compare[gi*COUNTER_SIZE +: COUNTER_SIZE] : cmp_s_reg[gi];
      assign pwm_next[gi]   = (count_next < cmp_s_next[gi]);
      assign match_next[gi] = tick && !load && (count_reg == cmp_s_reg[gi]);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cmp_s_reg[gi] <= '0;
        end else begin
          cmp_s_reg[gi] <= cmp_s_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg     <= '0;
      prescaler_reg <= '0;
      dir_down_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      running_reg   <= 1'b1;
      match_reg     <= '0;
      pwm_reg       <= '0;
      top_s_reg     <= '1;
    end else begin
      count_reg     <= count_next;
      prescaler_reg <= prescaler_next;
      dir_down_reg  <= dir_down_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      running_reg   <= running_next;
      match_reg     <= match_next;
      pwm_reg       <= pwm_next;
      top_s_reg     <= top_s_next;
    end
  end

  assign count     = count_reg;
  assign dir_down  = dir_down_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
  assign match     = match_reg;
  assign pwm_out   = pwm_reg;
  assign running   = running_reg;

endmodule

// File: tb/tb_pwm_timer.sv
// Directed bench for pwm_timer: vector table for up/up-down/down periods, hand sequences
// for shadow update, one-shot halt/reload and asynchronous reset.
module tb_pwm_timer;
  localparam int CW = 32;
  localparam int CH = 4;
  localparam int PW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [1:0]       mode;
  logic [PW-1:0]    prescale;
  logic [CW-1:0]    top;
  logic [CH*CW-1:0] compare;
  logic             load;
  logic [CW-1:0]    load_value;
  logic [CW-1:0]    count;
  logic             dir_down;
  logic             overflow;
  logic             underflow;
  logic [CH-1:0]    match;
  logic [CH-1:0]    pwm_out;
  logic             running;

  int checks   = 0;
  int failures = 0;

  pwm_timer #(.COUNTER_SIZE(CW), .CHANNELS(CH), .PRESCALE_SIZE(PW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .prescale(prescale),
    .top(top), .compare(compare), .load(load), .load_value(load_value),
    .count(count), .dir_down(dir_down), .overflow(overflow), .underflow(underflow),
    .match(match), .pwm_out(pwm_out), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ld;
    logic          en;
    logic [1:0]    md;
    logic [PW-1:0] pre;
    logic [CW-1:0] tp;
    logic [CW-1:0] cmp0;
    logic [CW-1:0] lv;
    logic [CW-1:0] exp_count;
    logic          exp_ovf;
    logic          exp_unf;
    logic          exp_dir;
    logic          exp_run;
    logic [CH-1:0] exp_match;
    logic [CH-1:0] exp_pwm;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  task automatic add(input logic ld, input logic en, input logic [1:0] md, input logic [PW-1:0] pre,
                     input logic [CW-1:0] tp, input logic [CW-1:0] cmp0, input logic [CW-1:0] lv,
                     input logic [CW-1:0] ec, input logic eo, input logic eu, input logic ed,
                     input logic er, input logic [CH-1:0] em, input logic [CH-1:0] ep);
    vec_t t;
    t.ld = ld; t.en = en; t.md = md; t.pre = pre; t.tp = tp; t.cmp0 = cmp0; t.lv = lv;
    t.exp_count = ec; t.exp_ovf = eo; t.exp_unf = eu; t.exp_dir = ed; t.exp_run = er;
    t.exp_match = em; t.exp_pwm = ep;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 2'b00; prescale = '0; top = '0;
    load = 1'b0; load_value = '0; compare = '0;
    compare[1*CW +: CW] = 32'd5;
    compare[2*CW +: CW] = 32'd0;
    compare[3*CW +: CW] = 32'd4;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 0, count, 0);
    chk("rst_flags", 0, {28'd0, overflow, underflow, dir_down, running}, 32'b0001);
    chk("rst_match", 0, match, 0);
    chk("rst_pwm", 0, pwm_out, 0);
    $display("reset count=%0d running=%0b pwm=%b", count, running, pwm_out);
    reset = 1'b0;

    // Up mode, top=4, compares {4,0,5,2}
    add(0,0,2'b00,0,4,2,0, 0,0,0,0,1,4'b0000,4'b1011);
    add(0,1,2'b00,0,4,2,0, 1,0,0,0,1,4'b0100,4'b1011);
    add(0,1,2'b00,0,4,2,0, 2,0,0,0,1,4'b0000,4'b1010);
    add(0,1,2'b00,0,4,2,0, 3,0,0,0,1,4'b0001,4'b1010);
    add(0,1,2'b00,0,4,2,0, 4,0,0,0,1,4'b0000,4'b0010);
    add(0,1,2'b00,0,4,2,0, 0,1,0,0,1,4'b1000,4'b1011);
    add(0,1,2'b00,0,4,2,0, 1,0,0,0,1,4'b0100,4'b1011);
    // Up-down mode, top=3, prescale=1
    add(1,0,2'b10,1,3,2,0, 0,0,0,0,1,4'b0000,4'b1011);
    add(0,1,2'b10,1,3,2,0, 0,0,0,0,1,4'b0000,4'b1011);
    add(0,1,2'b10,1,3,2,0, 1,0,0,0,1,4'b0100,4'b1011);
    add(0,1,2'b10,1,3,2,0, 1,0,0,0,1,4'b0000,4'b1011);
    add(0,1,2'b10,1,3,2,0, 2,0,0,0,1,4'b0000,4'b1010);
    add(0,1,2'b10,1,3,2,0, 2,0,0,0,1,4'b0000,4'b1010);
    add(0,1,2'b10,1,3,2,0, 3,0,0,0,1,4'b0001,4'b1010);
    add(0,1,2'b10,1,3,2,0, 3,0,0,0,1,4'b0000,4'b1010);
    add(0,1,2'b10,1,3,2,0, 2,1,0,1,1,4'b0000,4'b1010);
    add(0,1,2'b10,1,3,2,0, 2,0,0,1,1,4'b0000,4'b1010);
    add(0,1,2'b10,1,3,2,0, 1,0,0,1,1,4'b0001,4'b1011);
    add(0,1,2'b10,1,3,2,0, 1,0,0,1,1,4'b0000,4'b1011);
    add(0,1,2'b10,1,3,2,0, 0,0,0,1,1,4'b0000,4'b1011);
    add(0,1,2'b10,1,3,2,0, 0,0,0,1,1,4'b0000,4'b1011);
    add(0,1,2'b10,1,3,2,0, 1,0,1,0,1,4'b0100,4'b1011);
    add(0,1,2'b10,1,3,2,0, 1,0,0,0,1,4'b0000,4'b1011);
    // Down mode, top=5, load 3 together with enable
    add(1,1,2'b01,0,5,4,3, 3,0,0,0,1,4'b0000,4'b1011);
    add(0,1,2'b01,0,5,4,3, 2,0,0,0,1,4'b0000,4'b1011);
    add(0,1,2'b01,0,5,4,3, 1,0,0,0,1,4'b0000,4'b1011);
    add(0,1,2'b01,0,5,4,3, 0,0,0,0,1,4'b0000,4'b1011);
    add(0,1,2'b01,0,5,4,3, 5,0,1,0,1,4'b0100,4'b0000);
    add(0,1,2'b01,0,5,4,3, 4,0,0,0,1,4'b0010,4'b0010);
    add(0,1,2'b01,0,5,4,3, 3,0,0,0,1,4'b1001,4'b1011);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      load = v.ld; enable = v.en; mode = v.md; prescale = v.pre; top = v.tp;
      compare[0 +: CW] = v.cmp0; load_value = v.lv;
      step();
      chk("vec_count", i, count, v.exp_count);
      chk("vec_overflow", i, overflow, v.exp_ovf);
      chk("vec_underflow", i, underflow, v.exp_unf);
      chk("vec_dir_down", i, dir_down, v.exp_dir);
      chk("vec_running", i, running, v.exp_run);
      chk("vec_match", i, match, v.exp_match);
      chk("vec_pwm", i, pwm_out, v.exp_pwm);
      $display("vec %0d count=%0d ovf=%0b unf=%0b dir=%0b match=%b pwm=%b",
               i, count, overflow, underflow, dir_down, match, pwm_out);
    end

    // Shadowed top/compare change mid-period
    load = 1'b1; load_value = 0; mode = 2'b00; prescale = 0; top = 9; enable = 1'b1;
    compare[0 +: CW] = 32'd3;
    step();
    load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("shadow_count_a", k, count, k);
      $display("shadow count=%0d pwm0=%0b", count, pwm_out[0]);
    end
    top = 4; compare[0 +: CW] = 32'd7;
    for (int k = 6; k <= 9; k++) begin
      step();
      chk("shadow_count_b", k, count, k);
      chk("shadow_pwm_old", k, pwm_out[0], 0);
      $display("shadow count=%0d pwm0=%0b", count, pwm_out[0]);
    end
    step();
    chk("shadow_wrap_count", 10, count, 0);
    chk("shadow_wrap_ovf", 10, overflow, 1);
    chk("shadow_wrap_pwm", 10, pwm_out[0], 1);
    $display("shadow wrap count=%0d ovf=%0b pwm0=%0b", count, overflow, pwm_out[0]);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("shadow_new_count", k, count, k);
      chk("shadow_new_pwm", k, pwm_out[0], 1);
      $display("shadow count=%0d pwm0=%0b", count, pwm_out[0]);
    end
    step();
    chk("shadow_new_wrap", 0, {count[3:0], overflow}, 5'b00001);
    $display("shadow wrap count=%0d ovf=%0b", count, overflow);

    // One-shot halt and reload
    load = 1'b1; load_value = 0; mode = 2'b11; top = 2;
    step();
    load = 1'b0;
    step(); chk("os_count1", 1, count, 1);
    step(); chk("os_count2", 2, count, 2);
    step();
    chk("os_wrap", 3, {count[3:0], overflow, running}, 6'b000010);
    $display("oneshot wrap count=%0d ovf=%0b running=%0b", count, overflow, running);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("os_halted", k, {count[3:0], overflow, running}, 6'b000000);
      $display("oneshot halted count=%0d running=%0b", count, running);
    end
    load = 1'b1; load_value = 1;
    step();
    chk("os_reload", 0, {count[3:0], overflow, running}, 6'b000101);
    load = 1'b0;
    step(); chk("os_resume", 1, count, 2);
    step();
    chk("os_wrap2", 2, {count[3:0], overflow, running}, 6'b000010);
    $display("oneshot reload wrap count=%0d running=%0b", count, running);

    // Asynchronous reset mid-period
    load = 1'b1; load_value = 0; mode = 2'b00; top = 9; compare[0 +: CW] = 32'd9;
    step();
    load = 1'b0;
    repeat (7) step();
    chk("ar_before_count", 0, count, 7);
    chk("ar_before_pwm0", 0, pwm_out[0], 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_count", 0, count, 0);
    chk("ar_pwm", 0, pwm_out, 0);
    chk("ar_running", 0, running, 1);
    $display("async reset count=%0d pwm=%b running=%0b", count, pwm_out, running);
    @(negedge clk);
    reset = 1'b0;
    step(); chk("ar_restart1", 1, count, 1);
    step(); chk("ar_restart2", 2, count, 2);
    $display("after reset count=%0d", count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
